decode_issue_scoreboard: RTL and testbench

Parametrised decode-to-execute issue stage with a per-register pending-write scoreboard. It sits between the fetch-to-decode register and the execute stage, replacing the fixed `f_to_d_enable_ff`/`d_to_e_enable_ff` hazard handshake with valid/ready flow control. It tracks several in-flight writes per architectural register, stalls on RAW and WAW-overflow hazards, and squashes the issued instruction on a taken branch/jump.

---
 rtl/decode_issue_scoreboard.sv | 171 +++++++++++++++++
 tb/tb_decode_issue_scoreboard.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard: decode-to-execute issue register with valid/ready flow
// control and a per-register pending-write scoreboard. Stalls on RAW hazards and on
// too many in-flight writes to one register, and squashes the issued instruction on
// a taken branch/jump.
// Optional feature macro: DECODE_WB_BYPASS_EN - a source register retiring its last
// pending write this cycle via writeback is treated as ready in the same cycle.

module decode_issue_scoreboard #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int REGISTER_SIZE      = 5,
  parameter int OPCODE             = 7,
  parameter int MAX_PENDING        = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTRUCTION_LENGTH-1:0] instruction,
  input  logic [XLEN-1:0]               PC_in,
  input  logic                          wb_enable,
  input  logic [REGISTER_SIZE-1:0]      wb_addr,
  input  logic                          branch_taken,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTRUCTION_LENGTH-1:0] out_instruction,
  output logic [XLEN-1:0]               out_PC,
  output logic [REGISTER_SIZE-1:0]      out_rs1,
  output logic [REGISTER_SIZE-1:0]      out_rs2,
  output logic [REGISTER_SIZE-1:0]      out_rd,
  output logic                          out_rd_write,
  output logic                          stall
);

  localparam int CW   = $clog2(MAX_PENDING + 1);
  localparam int NREG = 2 ** REGISTER_SIZE;

  localparam logic [OPCODE-1:0] OP_LUI    = OPCODE'(7'b0110111);
  localparam logic [OPCODE-1:0] OP_AUIPC  = OPCODE'(7'b0010111);
  localparam logic [OPCODE-1:0] OP_JAL    = OPCODE'(7'b1101111);
  localparam logic [OPCODE-1:0] OP_JALR   = OPCODE'(7'b1100111);
  localparam logic [OPCODE-1:0] OP_OPIMM  = OPCODE'(7'b0010011);
  localparam logic [OPCODE-1:0] OP_OP     = OPCODE'(7'b0110011);
  localparam logic [OPCODE-1:0] OP_LOAD   = OPCODE'(7'b0000011);
  localparam logic [OPCODE-1:0] OP_OPIMM32 = OPCODE'(7'b0011011);
  localparam logic [OPCODE-1:0] OP_OP32   = OPCODE'(7'b0111011);
  localparam logic [OPCODE-1:0] OP_BRANCH = OPCODE'(7'b1100011);
  localparam logic [OPCODE-1:0] OP_STORE  = OPCODE'(7'b0100011);

  logic [CW-1:0]                 r_cnt [NREG];
  logic [CW-1:0]                 w_cntNext [NREG];
  logic                          r_outValid;
  logic [INSTRUCTION_LENGTH-1:0] r_outInstr;
  logic [XLEN-1:0]               r_outPc;
  logic [REGISTER_SIZE-1:0]      r_outRs1;
  logic [REGISTER_SIZE-1:0]      r_outRs2;
  logic [REGISTER_SIZE-1:0]      r_outRd;
  logic                          r_outRdWrite;

  logic [OPCODE-1:0]        w_opcode;
  logic [REGISTER_SIZE-1:0] w_rd;
  logic [REGISTER_SIZE-1:0] w_rs1;
  logic [REGISTER_SIZE-1:0] w_rs2;
  logic                     w_writeClass;
  logic                     w_rdWrite;
  logic                     w_rs1Used;
  logic                     w_rs2Used;
  logic                     w_rs1Busy;
  logic                     w_rs2Busy;
  logic                     w_raw;
  logic                     w_waw;
  logic                     w_hazard;
  logic                     w_slotFree;
  logic                     w_issue;
  logic                     w_flushWrite;

  // Counter step: the issue increment is applied before the decrements so that a
  // same-cycle retire of a brand-new write nets out correctly; never drops below 0.
  function automatic logic [CW-1:0] nextCount(input logic [CW-1:0] cnt, input logic inc,
                                              input logic decWb, input logic decFlush);
    logic [CW:0] sum;
    sum = {1'b0, cnt} + (CW+1)'(inc);
    if (decWb && (sum != '0)) sum = sum - (CW+1)'(1);
    if (decFlush && (sum != '0)) sum = sum - (CW+1)'(1);
    return sum[CW-1:0];
  endfunction

  assign w_opcode = instruction[OPCODE-1:0];
  assign w_rd     = instruction[7 +: REGISTER_SIZE];
  assign w_rs1    = instruction[15 +: REGISTER_SIZE];
  assign w_rs2    = instruction[20 +: REGISTER_SIZE];

  assign w_writeClass = w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM,
                                         OP_OP, OP_LOAD, OP_OPIMM32, OP_OP32};
  assign w_rdWrite    = w_writeClass && (w_rd != '0);
  assign w_rs1Used    = !(w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign w_rs2Used    = w_opcode inside {OP_OP, OP_OP32, OP_BRANCH, OP_STORE};

  // Source busy check; with the bypass, a source retiring its only pending write now is free.
  always_comb begin
    w_rs1Busy = (r_cnt[w_rs1] != '0);
    w_rs2Busy = (r_cnt[w_rs2] != '0);
`ifdef DECODE_WB_BYPASS_EN
    if (wb_enable && (wb_addr == w_rs1) && (r_cnt[w_rs1] == CW'(1))) w_rs1Busy = 1'b0;
    if (wb_enable && (wb_addr == w_rs2) && (r_cnt[w_rs2] == CW'(1))) w_rs2Busy = 1'b0;
`endif
  end

  assign w_raw        = (w_rs1Used && w_rs1Busy) || (w_rs2Used && w_rs2Busy);
  assign w_waw        = w_rdWrite && (r_cnt[w_rd] == CW'(MAX_PENDING));
  assign w_hazard     = w_raw || w_waw;
  assign w_slotFree   = !r_outValid || out_ready;
  assign in_ready     = !branch_taken && !w_hazard && w_slotFree;
  assign stall        = in_valid && w_hazard && !branch_taken && w_slotFree;
  assign w_issue      = in_valid && in_ready;
  assign w_flushWrite = branch_taken && r_outValid && r_outRdWrite;

  // Next counter values: issue adds, writeback and squashed writes subtract; x0 stays 0.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_cntNext[i] = nextCount(r_cnt[i],
                               w_issue && w_rdWrite && (w_rd == REGISTER_SIZE'(i)),
                               wb_enable && (wb_addr == REGISTER_SIZE'(i)),
                               w_flushWrite && (r_outRd == REGISTER_SIZE'(i)));
    end
    w_cntNext[0] = '0;
  end

  // Scoreboard counters; reset forgets every pending write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= w_cntNext[i];
    end
  end

  // Issue register: flush wins, then load on issue, else drop once execute consumes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outValid   <= 1'b0;
      r_outInstr   <= '0;
      r_outPc      <= '0;
      r_outRs1     <= '0;
      r_outRs2     <= '0;
      r_outRd      <= '0;
      r_outRdWrite <= 1'b0;
    end else if (branch_taken) begin
      r_outValid <= 1'b0;
    end else if (w_issue) begin
      r_outValid   <= 1'b1;
      r_outInstr   <= instruction;
      r_outPc      <= PC_in;
      r_outRs1     <= w_rs1;
      r_outRs2     <= w_rs2;
      r_outRd      <= w_rd;
      r_outRdWrite <= w_rdWrite;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid       = r_outValid;
  assign out_instruction = r_outInstr;
  assign out_PC          = r_outPc;
  assign out_rs1         = r_outRs1;
  assign out_rs2         = r_outRs2;
  assign out_rd          = r_outRd;
  assign out_rd_write    = r_outRdWrite;

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// tb_decode_issue_scoreboard: table vectors, hand-written hazard/flush/reset sequences
// and a randomized run, all compared against a scoreboard model kept in the bench.
// Honours DECODE_WB_BYPASS_EN the same way the design does.

module tb_decode_issue_scoreboard;

  localparam int MAXP = 3;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] instruction;
  logic [63:0] pcIn;
  logic        wbEnable;
  logic [4:0]  wbAddr;
  logic        branchTaken;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstruction;
  logic [63:0] outPc;
  logic [4:0]  outRs1;
  logic [4:0]  outRs2;
  logic [4:0]  outRd;
  logic        outRdWrite;
  logic        stall;

  decode_issue_scoreboard #(
    .XLEN(64), .INSTRUCTION_LENGTH(32), .REGISTER_SIZE(5), .OPCODE(7), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .instruction(instruction), .PC_in(pcIn), .wb_enable(wbEnable), .wb_addr(wbAddr),
    .branch_taken(branchTaken), .out_valid(outValid), .out_ready(outReady),
    .out_instruction(outInstruction), .out_PC(outPc), .out_rs1(outRs1), .out_rs2(outRs2),
    .out_rd(outRd), .out_rd_write(outRdWrite), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: pending-write counts and the issue register contents
  int          mCnt [32];
  logic        mValid;
  logic [31:0] mInstr;
  logic [63:0] mPc;
  logic        mInReady;
  logic        mStall;

  logic lastInReady;
  logic lastStall;

  typedef struct {
    logic        inValid;
    logic [31:0] instr;
    logic        wbEnable;
    logic [4:0]  wbAddr;
    logic        outReady;
    logic        expInReady;
    logic        expStall;
    logic        expOutValid;
    logic [4:0]  expOutRd;
  } vec_t;

  vec_t vecs [10];
  logic [6:0] ops [12];

  function automatic logic [31:0] encAddi(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] encAdd(int rd, int rs1, int rs2);
    return {7'b0000000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic bit isWrite(logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011,
                      7'b0110011, 7'b0000011, 7'b0011011, 7'b0111011};
  endfunction

  function automatic bit usesRs1(logic [6:0] op);
    return !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction

  function automatic bit usesRs2(logic [6:0] op);
    return op inside {7'b0110011, 7'b0111011, 7'b1100011, 7'b0100011};
  endfunction

  function automatic bit srcBusy(int r, logic wbe, logic [4:0] wba);
    if (r == 0 || mCnt[r] == 0) return 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    if (wbe && int'(wba) == r && mCnt[r] == 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int r = 0; r < 32; r++) mCnt[r] = 0;
    mValid = 1'b0;
    mInstr = '0;
    mPc    = '0;
  endtask

  // One clock cycle: drive, check the combinational outputs, clock, update model, check the register
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                               input logic wbe, input logic [4:0] wba, input logic br,
                               input logic ordy);
    logic [6:0] op;
    int rd, rs1, rs2, delta;
    bit wr, haz, free, issue, flushWr;
    @(negedge clk);
    inValid = v; instruction = ins; pcIn = pc; wbEnable = wbe; wbAddr = wba;
    branchTaken = br; outReady = ordy;
    #1;
    op  = ins[6:0];
    rd  = int'(ins[11:7]);
    rs1 = int'(ins[19:15]);
    rs2 = int'(ins[24:20]);
    wr  = isWrite(op) && rd != 0;
    haz = (usesRs1(op) && srcBusy(rs1, wbe, wba)) || (usesRs2(op) && srcBusy(rs2, wbe, wba)) ||
          (wr && mCnt[rd] == MAXP);
    free     = !mValid || ordy;
    mInReady = !br && !haz && free;
    mStall   = v && haz && !br && free;
    checkOutput("in_ready", {63'b0, inReady}, {63'b0, mInReady});
    checkOutput("stall", {63'b0, stall}, {63'b0, mStall});
    lastInReady = inReady;
    lastStall   = stall;
    @(posedge clk);
    issue   = v && mInReady;
    flushWr = br && mValid && isWrite(mInstr[6:0]) && (mInstr[11:7] != 5'd0);
    for (int r = 1; r < 32; r++) begin
      delta = 0;
      if (issue && wr && rd == r) delta++;
      if (wbe && int'(wba) == r) delta--;
      if (flushWr && int'(mInstr[11:7]) == r) delta--;
      mCnt[r] = (mCnt[r] + delta < 0) ? 0 : mCnt[r] + delta;
    end
    if (br) mValid = 1'b0;
    else if (issue) begin
      mValid = 1'b1; mInstr = ins; mPc = pc;
    end else if (ordy) mValid = 1'b0;
    #1;
    checkOutput("out_valid", {63'b0, outValid}, {63'b0, mValid});
    if (mValid) begin
      checkOutput("out_instruction", {32'b0, outInstruction}, {32'b0, mInstr});
      checkOutput("out_PC", outPc, mPc);
      checkOutput("out_rd", {59'b0, outRd}, {59'b0, mInstr[11:7]});
      checkOutput("out_rs1", {59'b0, outRs1}, {59'b0, mInstr[19:15]});
      checkOutput("out_rs2", {59'b0, outRs2}, {59'b0, mInstr[24:20]});
      checkOutput("out_rd_write", {63'b0, outRdWrite},
                  {63'b0, isWrite(mInstr[6:0]) && (mInstr[11:7] != 5'd0)});
    end
  endtask

  task automatic idle(input logic wbe, input logic [4:0] wba);
    applyStimulus(1'b0, 32'h0, 64'h0, wbe, wba, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] ins;
    logic        wbe, br;
    logic [4:0]  wba;
    int          r;

    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011,
            7'b0000011, 7'b0011011, 7'b0111011, 7'b1100011, 7'b0100011, 7'b0000000};

    // {inValid, instr, wbEnable, wbAddr, outReady, expInReady, expStall, expOutValid, expOutRd}
    vecs[0] = '{1'b1, encAddi(1, 0, 1), 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1};
    vecs[1] = '{1'b1, encAddi(2, 0, 2), 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2};
    vecs[2] = '{1'b1, encAddi(3, 0, 3), 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3};
    vecs[3] = '{1'b1, encAddi(4, 0, 4), 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4};
    vecs[4] = '{1'b1, encAdd(5, 1, 2),  1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[5] = '{1'b0, 32'h0,            1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[6] = '{1'b0, 32'h0,            1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[7] = '{1'b1, encAdd(5, 1, 2),  1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5};
    vecs[8] = '{1'b1, encAddi(10, 0, 0), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5};
    vecs[9] = '{1'b1, encAdd(6, 5, 5),  1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};

    rst = 1'b0; inValid = 1'b0; instruction = '0; pcIn = '0; wbEnable = 1'b0;
    wbAddr = '0; branchTaken = 1'b0; outReady = 1'b0;
    resetModel();
    #3;
    checkOutput("reset_out_valid", {63'b0, outValid}, 64'd0);
    checkOutput("reset_out_instruction", {32'b0, outInstruction}, 64'd0);
    checkOutput("reset_out_PC", outPc, 64'd0);
    checkOutput("reset_out_rd", {59'b0, outRd}, 64'd0);
    checkOutput("reset_out_rd_write", {63'b0, outRdWrite}, 64'd0);
    checkOutput("reset_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", {63'b0, inReady}, 64'd1);

    // Table: back-to-back independent issues, RAW stall, backpressure
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].inValid, vecs[i].instr, 64'h1000 + 64'(i * 4), vecs[i].wbEnable,
                    vecs[i].wbAddr, 1'b0, vecs[i].outReady);
      checkOutput($sformatf("vec%0d_in_ready", i), {63'b0, lastInReady}, {63'b0, vecs[i].expInReady});
      checkOutput($sformatf("vec%0d_stall", i), {63'b0, lastStall}, {63'b0, vecs[i].expStall});
      checkOutput($sformatf("vec%0d_out_valid", i), {63'b0, outValid}, {63'b0, vecs[i].expOutValid});
      if (vecs[i].expOutValid)
        checkOutput($sformatf("vec%0d_out_rd", i), {59'b0, outRd}, {59'b0, vecs[i].expOutRd});
    end

    // RAW resolution on x5 for ADD x6,x5,x5
`ifdef DECODE_WB_BYPASS_EN
    applyStimulus(1'b1, encAdd(6, 5, 5), 64'h2000, 1'b1, 5'd5, 1'b0, 1'b1);
    checkOutput("raw_bypass_in_ready", {63'b0, lastInReady}, 64'd1);
    checkOutput("raw_bypass_stall", {63'b0, lastStall}, 64'd0);
    checkOutput("raw_bypass_out_rd", {59'b0, outRd}, 64'd6);
`else
    applyStimulus(1'b1, encAdd(6, 5, 5), 64'h2000, 1'b1, 5'd5, 1'b0, 1'b1);
    checkOutput("raw_wb_cycle_stall", {63'b0, lastStall}, 64'd1);
    applyStimulus(1'b1, encAdd(6, 5, 5), 64'h2000, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("raw_after_wb_in_ready", {63'b0, lastInReady}, 64'd1);
    checkOutput("raw_after_wb_out_rd", {59'b0, outRd}, 64'd6);
`endif
    idle(1'b0, 5'd0);

    // WAW overflow on x7
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, encAddi(7, 0, k), 64'h3000, 1'b0, 5'd0, 1'b0, 1'b1);
      checkOutput("waw_fill_in_ready", {63'b0, lastInReady}, 64'd1);
    end
    applyStimulus(1'b1, encAddi(7, 0, 3), 64'h3010, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("waw_full_stall", {63'b0, lastStall}, 64'd1);
    applyStimulus(1'b1, encAddi(7, 0, 3), 64'h3010, 1'b1, 5'd7, 1'b0, 1'b1);
    checkOutput("waw_wb_cycle_stall", {63'b0, lastStall}, 64'd1);
    applyStimulus(1'b1, encAddi(7, 0, 3), 64'h3010, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("waw_release_in_ready", {63'b0, lastInReady}, 64'd1);
    checkOutput("waw_release_out_rd", {59'b0, outRd}, 64'd7);
    applyStimulus(1'b1, encAddi(7, 0, 4), 64'h3014, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("waw_full_again_stall", {63'b0, lastStall}, 64'd1);
    for (int k = 0; k < 3; k++) idle(1'b1, 5'd7);

    // Flush squashes a pending write to x8
    applyStimulus(1'b1, encAddi(8, 0, 1), 64'h4000, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, encAddi(11, 0, 0), 64'h4004, 1'b0, 5'd0, 1'b1, 1'b1);
    checkOutput("flush_in_ready", {63'b0, lastInReady}, 64'd0);
    checkOutput("flush_stall", {63'b0, lastStall}, 64'd0);
    checkOutput("flush_out_valid", {63'b0, outValid}, 64'd0);
    applyStimulus(1'b1, encAdd(12, 8, 8), 64'h4008, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("flush_cnt8_cleared", {63'b0, lastInReady}, 64'd1);

    // x9: issue+wb nets 0, then wb+flush nets -2
    applyStimulus(1'b1, encAddi(9, 0, 1), 64'h5000, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, encAddi(9, 0, 2), 64'h5004, 1'b1, 5'd9, 1'b0, 1'b1);
    checkOutput("x9_issue_with_wb", {63'b0, lastInReady}, 64'd1);
    applyStimulus(1'b1, encAddi(9, 0, 3), 64'h5008, 1'b0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, encAddi(13, 0, 0), 64'h500c, 1'b1, 5'd9, 1'b1, 1'b1);
    applyStimulus(1'b1, encAdd(14, 9, 9), 64'h5010, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("x9_net_clear", {63'b0, lastInReady}, 64'd1);

    // Asynchronous reset mid-stream
    applyStimulus(1'b1, encAddi(16, 0, 5), 64'h6000, 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    inValid = 1'b1; instruction = encAdd(17, 16, 16); pcIn = 64'h6004;
    outReady = 1'b0;
    #1;
    checkOutput("pre_reset_in_ready", {63'b0, inReady}, 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("async_out_valid", {63'b0, outValid}, 64'd0);
    checkOutput("async_out_instruction", {32'b0, outInstruction}, 64'd0);
    checkOutput("async_out_PC", outPc, 64'd0);
    checkOutput("async_out_rd", {59'b0, outRd}, 64'd0);
    checkOutput("async_out_rs1", {59'b0, outRs1}, 64'd0);
    checkOutput("async_out_rd_write", {63'b0, outRdWrite}, 64'd0);
    checkOutput("async_in_ready", {63'b0, inReady}, 64'd1);
    resetModel();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, encAdd(17, 16, 16), 64'h6004, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("after_reset_issue", {63'b0, lastInReady}, 64'd1);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 11)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      r   = $urandom_range(0, 7);
      wba = 5'(r);
      wbe = ($urandom_range(0, 2) == 0) && (r == 0 || mCnt[r] > 0);
      br  = ($urandom_range(0, 9) == 0);
      applyStimulus(1'($urandom_range(0, 1)), ins, {$urandom, $urandom}, wbe, wba, br,
                    1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
